// File: rtl/opp16_driver.sv
// Registered 16-bit output-port driver with load/set/clear/toggle ops
// and auto-clearing one-shot pulse bits sharing a single timer.
module opp16_driver #(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    PULSE_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  op,
  input  logic [15:0] wr_data,
  input  logic        mask_wr,
  output logic [15:0] port_out,
  output logic [15:0] pulse_mask,
  output logic        busy
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam logic [15:0] LEN = 16'(PULSE_LEN);

  if (PULSE_LEN < 1 || PULSE_LEN > 65535) begin : g_bad_len
    $error("opp16_driver %s (uuid %0d): PULSE_LEN out of range",
           NAME, UUID);
  end

  logic [15:0] word, mask, cnt;
  logic [15:0] base, nxt, touched, cnt_nxt;
  logic        expire, trig;

  // Expiry clears pulse bits before the op, so a write on the
  // expiry edge re-raises them without a low cycle.
  always_comb begin
    expire  = (cnt == 16'd1);
    base    = expire ? (word & ~mask) : word;
    nxt     = base;
    touched = wr_data;
    if (wr_en) begin
      unique case (op)
        OP_LOAD: nxt = wr_data;
        OP_SET:  nxt = base | wr_data;
        OP_CLR:  nxt = base & ~wr_data;
        OP_TGL:  nxt = base ^ wr_data;
        default: nxt = base;
      endcase
    end
    if (op == OP_LOAD) touched = 16'hFFFF;
    trig    = wr_en && ((nxt & mask & touched) != 16'd0);
    cnt_nxt = 16'd0;
    if (trig)
      cnt_nxt = LEN;
    else if ((nxt & mask) == 16'd0)
      cnt_nxt = 16'd0;
    else if (cnt != 16'd0)
      cnt_nxt = cnt - 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      mask <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      word <= nxt;
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != 16'd0);
      if (mask_wr) mask <= wr_data;
    end
  end

  assign port_out   = word;
  assign pulse_mask = mask;

endmodule

// File: tb/tb_opp16_driver.sv
// Scoreboard bench for opp16_driver with PULSE_LEN = 4.
// Expected port/mask/busy values are queued as stimulus is driven.
module tb_opp16_driver;

  localparam int PL = 4;

  localparam logic [1:0] LD  = 2'b00;
  localparam logic [1:0] ST  = 2'b01;
  localparam logic [1:0] CL  = 2'b10;
  localparam logic [1:0] TG  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] wr_data = '0;
  logic        mask_wr = 1'b0;
  logic [15:0] port_out, pulse_mask;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [15:0] port;
    logic [15:0] mask;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  opp16_driver #(.UUID(0), .NAME("tb"), .PULSE_LEN(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .op        (op),
    .wr_data   (wr_data),
    .mask_wr   (mask_wr),
    .port_out  (port_out),
    .pulse_mask(pulse_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] ep,
                      input logic [15:0] em, input logic eb);
    exp_t e;
    e.tag  = tag;
    e.port = ep;
    e.mask = em;
    e.busy = eb;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "/port"}, port_out, e.port);
    chk({e.tag, "/mask"}, pulse_mask, e.mask);
    chk({e.tag, "/busy"}, {15'd0, busy}, {15'd0, e.busy});
  endtask

  task automatic cyc(input string tag, input logic we,
                     input logic [1:0] o, input logic [15:0] d,
                     input logic mw, input logic [15:0] ep,
                     input logic [15:0] em, input logic eb);
    wr_en   = we;
    op      = o;
    wr_data = d;
    mask_wr = mw;
    push(tag, ep, em, eb);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    mask_wr = 1'b0;
    pop_check();
  endtask

  task automatic idle(input string tag, input int n,
                      input logic [15:0] ep, input logic [15:0] em,
                      input logic eb);
    for (int i = 0; i < n; i++)
      cyc(tag, 1'b0, LD, 16'h0, 1'b0, ep, em, eb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    push("rst_hold", 16'h0, 16'h0, 1'b0);
    pop_check();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // plain latch ops, mask = 0
    cyc("load",   1, LD, 16'hA5A5, 0, 16'hA5A5, 16'h0, 0);
    cyc("set",    1, ST, 16'h000F, 0, 16'hA5AF, 16'h0, 0);
    cyc("clear",  1, CL, 16'hA000, 0, 16'h05AF, 16'h0, 0);
    cyc("toggle", 1, TG, 16'hFFFF, 0, 16'hFA50, 16'h0, 0);
    idle("latch_hold", 2, 16'hFA50, 16'h0, 0);

    // basic pulse
    cyc("zero",   1, LD, 16'h0000, 0, 16'h0000, 16'h0, 0);
    cyc("mask1",  0, LD, 16'h0001, 1, 16'h0000, 16'h1, 0);
    cyc("p_trig", 1, ST, 16'h0003, 0, 16'h0003, 16'h1, 1);
    idle("p_high", PL - 1, 16'h0003, 16'h1, 1);
    cyc("p_end",  0, LD, 16'h0, 0, 16'h0002, 16'h1, 0);
    idle("p_after", 2, 16'h0002, 16'h1, 0);

    // retrigger mid-pulse
    cyc("r_trig", 1, ST, 16'h0001, 0, 16'h0003, 16'h1, 1);
    idle("r_high", 1, 16'h0003, 16'h1, 1);
    cyc("r_re",   1, ST, 16'h0001, 0, 16'h0003, 16'h1, 1);
    idle("r_ext", PL - 1, 16'h0003, 16'h1, 1);
    cyc("r_end",  0, LD, 16'h0, 0, 16'h0002, 16'h1, 0);

    // retrigger exactly on the expiry edge
    cyc("e_trig", 1, ST, 16'h0001, 0, 16'h0003, 16'h1, 1);
    idle("e_high", PL - 1, 16'h0003, 16'h1, 1);
    cyc("e_re",   1, ST, 16'h0001, 0, 16'h0003, 16'h1, 1);
    idle("e_ext", PL - 1, 16'h0003, 16'h1, 1);
    cyc("e_end",  0, LD, 16'h0, 0, 16'h0002, 16'h1, 0);

    // cancel by clearing the pulse bit
    cyc("c_trig", 1, ST, 16'h0001, 0, 16'h0003, 16'h1, 1);
    cyc("c_clr",  1, CL, 16'h0001, 0, 16'h0002, 16'h1, 0);
    idle("c_after", PL + 1, 16'h0002, 16'h1, 0);

    // mask write and op on the same edge use the old mask
    cyc("m_zero", 0, LD, 16'h0000, 1, 16'h0002, 16'h0, 0);
    cyc("m_both", 1, ST, 16'h0010, 1, 16'h0012, 16'h10, 0);
    idle("m_hold", PL + 2, 16'h0012, 16'h10, 0);
    cyc("m_trig", 1, ST, 16'h0010, 0, 16'h0012, 16'h10, 1);
    idle("m_high", PL - 1, 16'h0012, 16'h10, 1);
    cyc("m_end",  0, LD, 16'h0, 0, 16'h0002, 16'h10, 0);

    // async reset in the middle of a pulse
    cyc("a_trig", 1, LD, 16'hFFFF, 0, 16'hFFFF, 16'h10, 1);
    #3 rst = 1'b1;
    #1;
    push("a_async", 16'h0, 16'h0, 1'b0);
    pop_check();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    idle("a_after", PL + 1, 16'h0, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opp16_driver.md
# opp16_driver

Registered 16-bit output-port driver for SCM16. It holds the port word written by the CPU and applies load/set/clear/toggle operations to it. Selected bits can act as auto-clearing one-shot pulses timed by a shared counter. Bits `port_out[0]`..`port_out[15]` feed the `Input_1`..`Input_16` pins of the downstream 16-pin output-port stage, which ORs in the global enable.

## Interface

Parameters:
- `UUID`, default 0: instance identifier, XORed into child UUIDs per codebase practice.
- `NAME`, default "": instance label.
- `PULSE_LEN`, default 16: pulse duration in clock cycles. Legal range 1..65535.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `wr_en`, in, 1: apply `op` to the port word this edge.
- `op`, in, 2: 00 LOAD (word = `wr_data`), 01 SET (word |= `wr_data`), 10 CLEAR (word &= ~`wr_data`), 11 TOGGLE (word ^= `wr_data`).
- `wr_data`, in, 16: operand for `op`, or the new mask when `mask_wr` is high.
- `mask_wr`, in, 1: load `pulse_mask` from `wr_data` this edge.
- `port_out`, out, 16: registered port word; bit k drives `Input_(k+1)`.
- `pulse_mask`, out, 16: registered pulse-enable mask; bit set means that port bit is a one-shot.
- `busy`, out, 1: registered; high while the pulse counter is nonzero.

## Operation

- State: `word[15:0]`, `mask[15:0]`, `cnt[15:0]`.
- Output mapping: `port_out` = `word`, `pulse_mask` = `mask`, `busy` = (`cnt` != 0).
- Reset: while `rst` is high, `word`, `mask` and `cnt` are all 0. This forces `port_out` = 0, `pulse_mask` = 0 and `busy` = 0 immediately, with no clock required. Reset mid-pulse aborts the pulse.
- Per-edge evaluation order, always using the current (old) `mask`:
  1. Expiry. `exp` = 1 if `cnt` == 1. `base` = `word` & ~`mask` when `exp`, else `word`.
  2. Operation. `next` = op(`base`, `wr_data`) when `wr_en`, else `base`.
  3. Touched bits. `touched` = 16'hFFFF for LOAD, else `wr_data`.
  4. Retrigger. `trig` = `wr_en` and (`next` & `mask` & `touched`) != 0.
  5. Counter:
     - `trig` → `cnt` = `PULSE_LEN`;
     - else (`next` & `mask`) == 0 → `cnt` = 0;
     - else `cnt` != 0 → `cnt` = `cnt` − 1;
     - else → `cnt` stays 0.
  6. `word` = `next`. If `mask_wr`, `mask` = `wr_data`; the new mask takes effect from the following edge.
- Non-pulse bits (`mask` = 0) are plain latches: they change only via `op`.
- The counter is shared by all pulse bits. Any retrigger extends every currently-high pulse bit to a full `PULSE_LEN` from that edge.
- Clearing all pulse bits by `op` cancels the timer (`cnt` = 0) in the same edge.
- Changing `mask` does not alter `word`. A bit newly added to the mask while high is cleared at the next expiry only if the timer is running; otherwise it stays high until written.
- A TOGGLE that drives a pulse bit 1→0 with `wr_data` bit set: that bit is low in `next`, so it does not trigger.

## Timing

- Write latency: 1 edge. The `op` applied at edge N is visible on `port_out` after edge N.
- Pulse width: a triggering write at edge N loads `cnt` = `PULSE_LEN`. The pulse bits clear at edge N+`PULSE_LEN`, so they are high for exactly `PULSE_LEN` cycles. With `PULSE_LEN` = 1 they are high for one cycle.
- `busy` rises after the trigger edge and falls after the same edge where the pulse bits clear.
- Write during the expiry edge: the expiry clear is applied first, then `op`. A SET of a pulse bit on the expiry edge therefore keeps it high and reloads `cnt`, with no low glitch cycle.
- Retrigger on edge N+k (k < `PULSE_LEN`): the clear moves to edge N+k+`PULSE_LEN`.
- `mask_wr` together with `wr_en` on the same edge: `op`, trigger and expiry use the old mask.
- No combinational path from inputs to outputs.

## Test plan

- **Async reset:** assert `rst` mid-cycle with `word` = 16'hFFFF and `cnt` = 5 → `port_out` = 0, `busy` = 0 before the next edge; both stay 0 after release with no writes.
- **Latch ops, mask = 0:**
  - LOAD 16'hA5A5 → 16'hA5A5.
  - SET 16'h000F → 16'hA5AF.
  - CLEAR 16'hA000 → 16'h05AF.
  - TOGGLE 16'hFFFF → 16'hFA50.
  - Each value appears 1 edge after its write; `busy` stays 0 throughout.
- **Pulse, `PULSE_LEN` = 4:** `mask` = 16'h0001, SET 16'h0003 at edge N → `port_out` = 16'h0003 for 4 cycles, then 16'h0002 after edge N+4; `busy` is high over the same window.
- **Retrigger:** same setup, SET 16'h0001 again at edge N+2 → bit 0 clears after edge N+6. A SET at exactly edge N+4 → no low cycle on bit 0, and the clear moves to edge N+8.
- **Cancel:** pulse running, CLEAR 16'h0001 at edge N+1 → bit 0 low and `busy` low after edge N+1; no later change to `port_out`.
- **Mask/op same edge:** `mask` = 0, `mask_wr` = 1 with `wr_data` = 16'h0010 plus `wr_en` SET 16'h0010 → bit 4 set, `busy` = 0, bit 4 stays high indefinitely. A subsequent SET 16'h0010 starts a `PULSE_LEN` pulse.
